ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 10, meaning RAM address width in bits.
REQ-002 SHALL have parameter DW, default 32, meaning RAM data width in bits.
REQ-003 SHALL have parameter RD_LAT, default 1, meaning RAM read latency in clk cycles, legal range 1..3.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RSTN, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port cpu_req, input, 1, CPU-side access request, held until cpu_ready.
REQ-007 SHALL have port cpu_we, input, 1, CPU write (1) or read (0), valid with cpu_req.
REQ-008 SHALL have port cpu_addr, input, AW, CPU word address.
REQ-009 SHALL have port cpu_wdata, input, DW, CPU write data.
REQ-010 SHALL have port cpu_ready, output, 1, one-cycle completion pulse for the CPU.
REQ-011 SHALL have port cpu_rdata, output, DW, CPU read data, valid while cpu_ready=1.
REQ-012 SHALL have port vid_req, input, 1, video/game reader request (read-only), held until vid_ready.
REQ-013 SHALL have port vid_addr, input, AW, video reader word address.
REQ-014 SHALL have port vid_ready, output, 1, one-cycle completion pulse for the reader.
REQ-015 SHALL have port vid_rdata, output, DW, reader data, valid while vid_ready=1.
REQ-016 SHALL have port video, input, 1, 1 = inside active display area.
REQ-017 SHALL have ports ram_addr (output, AW), ram_we (output, 1), ram_din (output, DW), ram_dout (input, DW), the RAM port.
REQ-018 SHALL have port grant, output, 2, one-hot owner: bit0 = CPU, bit1 = video, 00 = idle.

Function
REQ-019 SHALL implement the states IDLE, ACCESS, WAIT and DONE.
REQ-020 In IDLE with any request pending, the arbiter SHALL select the owner, set grant, and go to ACCESS on the next edge.
REQ-021 In ACCESS, ram_addr/ram_we/ram_din SHALL carry the owner's request for exactly one cycle; ram_we=1 only for a CPU write.
REQ-022 From ACCESS, a write SHALL go to DONE; a read SHALL go to WAIT, stay there RD_LAT-1 further cycles, then go to DONE.
REQ-023 In DONE, the owner's ready SHALL pulse for one cycle; for a read, the rdata register SHALL be captured from ram_dout exactly RD_LAT cycles after ACCESS.
REQ-024 After DONE, the arbiter SHALL return to IDLE and clear grant; there is no back-to-back ACCESS.
REQ-025 Read latency from request sampled in IDLE to ready SHALL be RD_LAT+2 cycles; write latency SHALL be 2 cycles.
REQ-026 Fixed priority on simultaneous requests: video wins when video=1; CPU wins when video=0.
REQ-027 cpu_rdata and vid_rdata SHALL hold their last captured value between accesses.
REQ-028 A request deasserted after grant SHALL still complete, and ready SHALL still pulse.
REQ-029 ram_addr and ram_din SHALL be 0 outside ACCESS.
REQ-030 ram_we SHALL be 0 outside ACCESS.
REQ-031 Requester inputs SHALL be sampled only in IDLE and registered at ACCESS entry; changes during ACCESS, WAIT or DONE are ignored.
REQ-032 If a requester still holds req in its DONE cycle, the arbiter SHALL treat it as a new request in the following IDLE.

Reset
REQ-033 RSTN=0 SHALL force, without waiting for clk: state=IDLE, grant=00, ram_we=0, ram_addr=0, ram_din=0, both ready=0, both rdata=0, last-owner=video.
REQ-034 Reset mid-access SHALL abort the access with no ready pulse; operation resumes on the first edge after RSTN rises.

Configuration
REQ-035 With macro RAM_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the requester not served last, and the video input SHALL be ignored for arbitration.
REQ-036 Without RAM_ARB_ROUND_ROBIN_EN, the fixed priority of REQ-026 SHALL apply, and the last-owner register SHALL be absent.

Verification
REQ-037 CPU write, addr=0x005, data=0xDEADBEEF, vid_req=0 -> ram_we=1 for one cycle with ram_addr=0x005, then cpu_ready pulses 2 cycles after request.
REQ-038 CPU read of addr 0x005 after REQ-037, RD_LAT=1 -> cpu_rdata=0xDEADBEEF with cpu_ready 3 cycles after request.
REQ-039 Simultaneous cpu_req and vid_req, video=1, fixed priority -> video served first, CPU granted in the IDLE following video DONE.
REQ-040 Simultaneous requests, video=0, fixed priority -> CPU served first; with RAM_ARB_ROUND_ROBIN_EN and both requests held for 4 accesses -> grant sequence CPU, video, CPU, video.
REQ-041 RSTN pulled low in WAIT of a video read -> grant=00 and ram_we=0 immediately, no vid_ready; after release, a held vid_req completes normally.
REQ-042 RD_LAT=3 video read of addr 0x3FF -> ram_addr=0x3FF in ACCESS, vid_ready 5 cycles after request, vid_rdata equal to the RAM model contents.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter (CPU read/write, video reader read-only) in front of a single RAM port.
// Define RAM_ARB_ROUND_ROBIN_EN to replace the video-driven fixed priority with round-robin.
module ram_port_arbiter #(
    parameter int AW     = 10,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          RSTN,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ready,
    output logic [DW-1:0] cpu_rdata,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ready,
    output logic [DW-1:0] vid_rdata,
    input  logic          video,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic [1:0]    grant,
    output logic [1:0]    dbg_state
);

    // Handshake: a requester raises *_req with its command stable and keeps it up until
    // it sees the one-cycle *_ready pulse; the command is taken only while the arbiter is idle.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_din_q, ram_din_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          cpu_ready_q, cpu_ready_d;
    logic          vid_ready_q, vid_ready_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] vid_rdata_q, vid_rdata_d;
    logic          pick_vid;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic          last_vid_q, last_vid_d;
`endif

    always_comb begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
        pick_vid    = vid_req & (~cpu_req | ~last_vid_q);
        last_vid_d  = last_vid_q;
`else
        pick_vid    = vid_req & (~cpu_req | video);
`endif
        state_d     = state_q;
        grant_d     = grant_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = '0;
        ram_din_d   = '0;
        cnt_d       = cnt_q;
        cpu_ready_d = 1'b0;
        vid_ready_d = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        vid_rdata_d = vid_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req || vid_req) begin
                    state_d = S_ACCESS;
                    if (pick_vid) begin
                        grant_d    = 2'b10;
                        ram_addr_d = vid_addr;
                    end else begin
                        grant_d    = 2'b01;
                        ram_addr_d = cpu_addr;
                        ram_we_d   = cpu_we;
                        ram_din_d  = cpu_we ? cpu_wdata : '0;
                    end
`ifdef RAM_ARB_ROUND_ROBIN_EN
                    last_vid_d = pick_vid;
`endif
                end
            end
            S_ACCESS: begin
                // ram_we_q still reflects the command issued this cycle
                if (ram_we_q) begin
                    state_d     = S_DONE;
                    cpu_ready_d = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = 2'(RD_LAT - 1);
                end
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = S_DONE;
                    if (grant_q[1]) begin
                        vid_ready_d = 1'b1;
                        vid_rdata_d = ram_dout;
                    end else begin
                        cpu_ready_d = 1'b1;
                        cpu_rdata_d = ram_dout;
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= S_IDLE;
            grant_q     <= 2'b00;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            cnt_q       <= 2'd0;
            cpu_ready_q <= 1'b0;
            vid_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_vid_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            cnt_q       <= cnt_d;
            cpu_ready_q <= cpu_ready_d;
            vid_ready_q <= vid_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_rdata_q <= vid_rdata_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_vid_q  <= last_vid_d;
`endif
        end
    end

    assign cpu_ready = cpu_ready_q;
    assign cpu_rdata = cpu_rdata_q;
    assign vid_ready = vid_ready_q;
    assign vid_rdata = vid_rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_din   = ram_din_q;
    assign grant     = grant_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: RD_LAT=1 main instance checked by a cycle-stamped
// scoreboard, plus an RD_LAT=3 instance for the long-latency read at the top address.
module tb_ram_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int RD_LAT = 1;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [1:0]    grant;
    int            cyc;
  } cmd_t;

  typedef struct packed {
    logic          is_vid;
    logic [DW-1:0] cpu_d;
    logic [DW-1:0] vid_d;
    int            cyc;
  } rsp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic RSTN;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (RD_LAT=1) ----------------
  logic          cpu_req, cpu_we, cpu_ready, vid_req, vid_ready, video, ram_we;
  logic [AW-1:0] cpu_addr, vid_addr, ram_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata, vid_rdata, ram_din, ram_dout;
  logic [1:0]    grant, dbg_state;

  ram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) u_dut (
    .clk(clk), .RSTN(RSTN),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ready(vid_ready), .vid_rdata(vid_rdata),
    .video(video),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .grant(grant), .dbg_state(dbg_state)
  );

  logic [DW-1:0] mem1 [0:(1<<AW)-1];
  logic [DW-1:0] pipe1;
  always @(posedge clk) begin
    if (ram_we) mem1[ram_addr] <= ram_din;
    pipe1 <= mem1[ram_addr];
  end
  assign ram_dout = pipe1;

  // ---------------- second DUT (RD_LAT=3), video side only ----------------
  logic          cpu_req3, cpu_we3, cpu_ready3, vid_req3, vid_ready3, ram_we3;
  logic [AW-1:0] cpu_addr3, vid_addr3, ram_addr3;
  logic [DW-1:0] cpu_wdata3, cpu_rdata3, vid_rdata3, ram_din3, ram_dout3;
  logic [1:0]    grant3, dbg_state3;

  ram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3)) u_dut3 (
    .clk(clk), .RSTN(RSTN),
    .cpu_req(cpu_req3), .cpu_we(cpu_we3), .cpu_addr(cpu_addr3), .cpu_wdata(cpu_wdata3),
    .cpu_ready(cpu_ready3), .cpu_rdata(cpu_rdata3),
    .vid_req(vid_req3), .vid_addr(vid_addr3), .vid_ready(vid_ready3), .vid_rdata(vid_rdata3),
    .video(video),
    .ram_addr(ram_addr3), .ram_we(ram_we3), .ram_din(ram_din3), .ram_dout(ram_dout3),
    .grant(grant3), .dbg_state(dbg_state3)
  );

  logic [DW-1:0] mem3 [0:(1<<AW)-1];
  logic [DW-1:0] p3a, p3b, p3c;
  always @(posedge clk) begin
    if (ram_we3) mem3[ram_addr3] <= ram_din3;
    p3a <= mem3[ram_addr3];
    p3b <= p3a;
    p3c <= p3b;
  end
  assign ram_dout3 = p3c;

  // ---------------- scoreboard state ----------------
  int   vectors = 0;
  int   miscompares = 0;
  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  logic [DW-1:0] exp_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_cpu_rdata;
  logic [DW-1:0] exp_vid_rdata;
  logic          exp_last_vid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic vid_wins(input logic vid_v);
`ifdef RAM_ARB_ROUND_ROBIN_EN
    return !exp_last_vid;
`else
    return vid_v;
`endif
  endfunction

  task automatic exp_cpu_write(input int acc, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_q.push_back('{we: 1'b1, addr: a, din: d, grant: 2'b01, cyc: acc});
    exp_mem[a] = d;
    rsp_q.push_back('{is_vid: 1'b0, cpu_d: exp_cpu_rdata, vid_d: exp_vid_rdata, cyc: acc + 1});
    exp_last_vid = 1'b0;
  endtask

  task automatic exp_cpu_read(input int acc, input logic [AW-1:0] a);
    cmd_q.push_back('{we: 1'b0, addr: a, din: '0, grant: 2'b01, cyc: acc});
    exp_cpu_rdata = exp_mem[a];
    rsp_q.push_back('{is_vid: 1'b0, cpu_d: exp_cpu_rdata, vid_d: exp_vid_rdata, cyc: acc + 1 + RD_LAT});
    exp_last_vid = 1'b0;
  endtask

  task automatic exp_vid_read(input int acc, input logic [AW-1:0] a);
    cmd_q.push_back('{we: 1'b0, addr: a, din: '0, grant: 2'b10, cyc: acc});
    exp_vid_rdata = exp_mem[a];
    rsp_q.push_back('{is_vid: 1'b1, cpu_d: exp_cpu_rdata, vid_d: exp_vid_rdata, cyc: acc + 1 + RD_LAT});
    exp_last_vid = 1'b1;
  endtask

  // ---------------- monitor ----------------
  cmd_t ce;
  rsp_t re;
  always @(negedge clk) begin
    if (RSTN) begin
      if (cmd_q.size() > 0 && cmd_q[0].cyc < cyc) begin
        ce = cmd_q.pop_front();
        vectors++; miscompares++;
        $display("FAIL ram_access_missing: expected access at cycle %0d, now cycle %0d", ce.cyc, cyc);
      end
      if (cmd_q.size() > 0 && cmd_q[0].cyc == cyc) begin
        ce = cmd_q.pop_front();
        vectors++;
        if ({ram_we, ram_addr, ram_din, grant} !== {ce.we, ce.addr, ce.din, ce.grant}) begin
          miscompares++;
          $display("FAIL ram_access cyc %0d: got we=%b addr=%h din=%h grant=%b, expected we=%b addr=%h din=%h grant=%b",
                   cyc, ram_we, ram_addr, ram_din, grant, ce.we, ce.addr, ce.din, ce.grant);
        end
      end else begin
        vectors++;
        if ({ram_we, ram_addr, ram_din} !== '0) begin
          miscompares++;
          $display("FAIL ram_idle cyc %0d: got we=%b addr=%h din=%h, expected all zero", cyc, ram_we, ram_addr, ram_din);
        end
      end

      if (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
        re = rsp_q.pop_front();
        vectors++; miscompares++;
        $display("FAIL ready_missing: expected ready at cycle %0d, now cycle %0d", re.cyc, cyc);
      end
      if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
        re = rsp_q.pop_front();
        vectors++;
        if ({vid_ready, cpu_ready, cpu_rdata, vid_rdata} !==
            {re.is_vid, !re.is_vid, re.cpu_d, re.vid_d}) begin
          miscompares++;
          $display("FAIL ready cyc %0d: got vid_ready=%b cpu_ready=%b cpu_rdata=%h vid_rdata=%h, expected %b %b %h %h",
                   cyc, vid_ready, cpu_ready, cpu_rdata, vid_rdata, re.is_vid, !re.is_vid, re.cpu_d, re.vid_d);
        end
      end else begin
        vectors++;
        if ({vid_ready, cpu_ready} !== 2'b00) begin
          miscompares++;
          $display("FAIL unexpected_ready cyc %0d: got vid_ready=%b cpu_ready=%b, expected 0 0", cyc, vid_ready, cpu_ready);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic cpu_go(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic vid_go(input logic [AW-1:0] a);
    vid_req = 1'b1; vid_addr = a;
  endtask

  task automatic cpu_wait_release();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!cpu_ready && n < 40);
    if (!cpu_ready) begin
      vectors++; miscompares++;
      $display("FAIL cpu_ready_timeout: got no cpu_ready within 40 cycles, expected a pulse");
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic vid_wait_release();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!vid_ready && n < 40);
    if (!vid_ready) begin
      vectors++; miscompares++;
      $display("FAIL vid_ready_timeout: got no vid_ready within 40 cycles, expected a pulse");
    end
    @(posedge clk); #1;
    vid_req = 1'b0;
  endtask

  task automatic both_once(input logic vid_v, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                           input logic [AW-1:0] va);
    int k;
    k = cyc;
    video = vid_v;
    cpu_go(1'b1, ca, cd);
    vid_go(va);
    if (vid_wins(vid_v)) begin
      exp_vid_read(k + 1, va);
      exp_cpu_write(k + 4 + RD_LAT, ca, cd);
    end else begin
      exp_cpu_write(k + 1, ca, cd);
      exp_vid_read(k + 4, va);
    end
    fork
      cpu_wait_release();
      vid_wait_release();
    join
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int k, m, acc, got, n;
    for (int i = 0; i < (1 << AW); i++) begin
      mem1[i] = '0; mem3[i] = '0; exp_mem[i] = '0;
    end
    mem3[(1 << AW) - 1] = 32'hA5C3_0FF1;
    exp_cpu_rdata = '0; exp_vid_rdata = '0; exp_last_vid = 1'b1;
    RSTN = 1'b0; video = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vid_req = 1'b0; vid_addr = '0;
    cpu_req3 = 1'b0; cpu_we3 = 1'b0; cpu_addr3 = '0; cpu_wdata3 = '0;
    vid_req3 = 1'b0; vid_addr3 = '0;

    // reset values, before any clock edge
    #2;
    chk("reset_grant", 64'(grant), 64'd0);
    chk("reset_ram", 64'({ram_we, ram_addr, ram_din}), 64'd0);
    chk("reset_ready", 64'({cpu_ready, vid_ready}), 64'd0);
    chk("reset_rdata", 64'({cpu_rdata, vid_rdata}), 64'd0);
    chk("reset_dut3", 64'({grant3, vid_ready3, vid_rdata3}), 64'd0);
    repeat (2) @(posedge clk);
    #1 RSTN = 1'b1;

    // CPU write 0x005; command inputs wiggled during ACCESS must not matter
    @(posedge clk); #1;
    k = cyc;
    cpu_go(1'b1, 10'h005, 32'hDEAD_BEEF);
    exp_cpu_write(k + 1, 10'h005, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    cpu_wdata = 32'hBAD0_BAD0; cpu_addr = 10'h3AA;
    cpu_wait_release();

    // CPU read back, issued in the IDLE cycle right after DONE
    k = cyc;
    cpu_go(1'b0, 10'h005, 32'h0);
    exp_cpu_read(k + 1, 10'h005);
    cpu_wait_release();

    // video read, request dropped once granted
    @(posedge clk); #1;
    k = cyc;
    vid_go(10'h005);
    exp_vid_read(k + 1, 10'h005);
    @(posedge clk); #1;
    vid_req = 1'b0;
    vid_wait_release();

    // simultaneous requests, video=1 then video=0
    @(posedge clk); #1;
    both_once(1'b1, 10'h020, 32'h1234_5678, 10'h005);
    @(posedge clk); #1;
    both_once(1'b0, 10'h021, 32'h0BAD_F00D, 10'h020);

    // reset asserted while a video read sits in WAIT
    @(posedge clk); #1;
    k = cyc;
    vid_go(10'h021);
    cmd_q.push_back('{we: 1'b0, addr: 10'h021, din: '0, grant: 2'b10, cyc: k + 1});
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1 RSTN = 1'b0;
    #1;
    chk("abort_grant", 64'(grant), 64'd0);
    chk("abort_ram_we", 64'(ram_we), 64'd0);
    chk("abort_ready", 64'({cpu_ready, vid_ready}), 64'd0);
    chk("abort_rdata", 64'({cpu_rdata, vid_rdata}), 64'd0);
    exp_cpu_rdata = '0; exp_vid_rdata = '0; exp_last_vid = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    m = cyc;
    RSTN = 1'b1;
    exp_vid_read(m + 1, 10'h021);
    vid_wait_release();

    // both requests held for four accesses, video=0
    k = cyc;
    video = 1'b0;
    cpu_go(1'b1, 10'h030, 32'h0000_0A5A);
    vid_go(10'h005);
    acc = k + 1;
    for (int i = 0; i < 4; i++) begin
      if (vid_wins(1'b0)) begin
        exp_vid_read(acc, 10'h005);
        acc = acc + 3 + RD_LAT;
      end else begin
        exp_cpu_write(acc, 10'h030, 32'h0000_0A5A);
        acc = acc + 3;
      end
    end
    got = 0; n = 0;
    while (got < 4 && n < 80) begin
      @(negedge clk);
      n++;
      if (cpu_ready || vid_ready) got++;
    end
    chk("held_ready_count", 64'(got), 64'd4);
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0; vid_req = 1'b0;

    // RD_LAT=3 instance: video read of the top address
    @(posedge clk); #1;
    vid_req3 = 1'b1; vid_addr3 = 10'h3FF;
    repeat (2) @(negedge clk);
    chk("lat3_access", 64'({ram_we3, ram_addr3, grant3}), 64'({1'b0, 10'h3FF, 2'b10}));
    repeat (3) @(negedge clk);
    chk("lat3_not_early", 64'(vid_ready3), 64'd0);
    @(negedge clk);
    chk("lat3_ready", 64'({vid_ready3, vid_rdata3}), 64'({1'b1, 32'hA5C3_0FF1}));
    @(posedge clk); #1;
    vid_req3 = 1'b0;

    repeat (6) @(posedge clk);
    while (cmd_q.size() > 0) begin
      ce = cmd_q.pop_front();
      vectors++; miscompares++;
      $display("FAIL ram_access_never: expected access at cycle %0d never checked", ce.cyc);
    end
    while (rsp_q.size() > 0) begin
      re = rsp_q.pop_front();
      vectors++; miscompares++;
      $display("FAIL ready_never: expected ready at cycle %0d never checked", re.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
